// File: rtl/canvas_write_arbiter.sv
// ---------------------------------------------------------------------------
// canvas_write_arbiter
//
// Arbitrates the single write port of a 1-bit-per-pixel canvas RAM between
// a full-canvas clear sweep and a stroke engine offering pixel writes.
// The clear always wins: from the cycle clear_req is seen until the sweep
// finishes, only sweep writes reach the RAM port. The sweep walks from the
// top address down to 0, writing 0 once per cycle.
//
// Optional build macro: CANVAS_STROKE_FIFO_EN
//   undefined : stroke writes pass straight through (zero latency) whenever
//               the arbiter is idle and no clear is being requested.
//   defined   : strokes are queued in a FIFO_DEPTH-entry buffer and drained
//               one per cycle while idle. A clear_req discards everything
//               queued up to and including its own cycle; strokes accepted
//               during the sweep survive and drain afterwards.
//
// Parameters
//   ADDR_W      canvas word address width (sweep length 2**ADDR_W)
//   FIFO_DEPTH  stroke buffer entries, power of two >= 2 (FIFO build only)
//
// Ports
//   clk           system clock
//   rst           synchronous active-high reset
//   clear_req     one-cycle request to clear the whole canvas
//   stroke_valid  stroke engine offers one pixel write
//   stroke_addr   pixel address {y[4:0], x[4:0]}
//   stroke_data   pixel value
//   stroke_ready  stroke write accepted this cycle when high with stroke_valid
//   write_addr    canvas RAM write address
//   write_enable  canvas RAM write strobe
//   write_data    canvas RAM write data
//   busy          clear sweep in progress (FSM state is CLEAR)
//   clear_done    one-cycle pulse after the final sweep write
//   editing       canvas holds a stroke pixel set since the last clear
//
// Handshake: a stroke transfer happens on a rising edge where stroke_valid
// and stroke_ready are both high; stroke_ready never depends on
// stroke_valid, and the engine must hold addr/data stable while waiting.
// ---------------------------------------------------------------------------
module canvas_write_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_req,
    input  logic              stroke_valid,
    input  logic [ADDR_W-1:0] stroke_addr,
    input  logic              stroke_data,
    output logic              stroke_ready,
    output logic [ADDR_W-1:0] write_addr,
    output logic              write_enable,
    output logic              write_data,
    output logic              busy,
    output logic              clear_done,
    output logic              editing
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] count;
    logic [ADDR_W-1:0] count_next;
    logic              sweep_last;

    // Stroke path as seen by the RAM port (either direct or FIFO head).
    logic              stroke_write;
    logic [ADDR_W-1:0] stroke_waddr;
    logic              stroke_wdata;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            clear_done <= 1'b0;
            editing    <= 1'b0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            clear_done <= sweep_last;
            if (clear_req) begin
                editing <= 1'b0;
            end else if (stroke_write && stroke_wdata) begin
                editing <= 1'b1;
            end
        end
    end

    // A clear request in either state (re)starts the sweep at the top.
    always_comb begin
        state_next = state;
        count_next = count;
        sweep_last = 1'b0;
        if (clear_req) begin
            state_next = CLEAR;
            count_next = LAST_ADDR;
        end else if (state == CLEAR) begin
            if (count == '0) begin
                state_next = IDLE;
                sweep_last = 1'b1;
            end else begin
                count_next = count - 1'b1;
            end
        end
    end

    assign busy = (state == CLEAR);

    // ---------------------------------------------------------- stroke path
`ifdef CANVAS_STROKE_FIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic              fifo_data [FIFO_DEPTH];
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PTR_W:0]    wr_ptr;
    logic [PTR_W:0]    rd_ptr;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    assign stroke_ready = !rst && !fifo_full;
    assign push         = stroke_valid && stroke_ready;
    assign pop          = !rst && (state == IDLE) && !clear_req && !fifo_empty;

    assign stroke_write = pop;
    assign stroke_waddr = fifo_addr[rd_ptr[PTR_W-1:0]];
    assign stroke_wdata = fifo_data[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (rst || clear_req) begin
            // clear_req also drops a push made in its own cycle.
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr[PTR_W-1:0]] <= stroke_addr;
            fifo_data[wr_ptr[PTR_W-1:0]] <= stroke_data;
        end
    end
`else
    assign stroke_ready = !rst && (state == IDLE) && !clear_req;
    assign stroke_write = stroke_valid && stroke_ready;
    assign stroke_waddr = stroke_addr;
    assign stroke_wdata = stroke_data;
`endif

    // ------------------------------------------------------------ RAM port
    always_comb begin
        write_enable = 1'b0;
        write_addr   = '0;
        write_data   = 1'b0;
        if (!rst) begin
            if (state == CLEAR) begin
                write_enable = 1'b1;
                write_addr   = count;
            end else if (stroke_write) begin
                write_enable = 1'b1;
                write_addr   = stroke_waddr;
                write_data   = stroke_wdata;
            end
        end
    end

endmodule
